reg_file_test_checker: RTL

//  Synthesizable self-check engine for the instruction-test benches.
//  - Waits for a test run to end. The end is a core halt or a cycle timeout.
//  - Then walks the register file and compares each register against an

---
 rtl/rf_check_pkg.sv | 12 +
 rtl/reg_file_test_checker_if.sv | 27 ++
 rtl/rf_scan_compare.sv | 89 ++++++++
 rtl/reg_file_test_checker.sv | 102 ++++++++++
 4 files changed

// File: rtl/rf_check_pkg.sv
// Shared constants for the register-file self-check engine.
// State encoding and the read-to-compare latency of the scan pipeline.
package rf_check_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CHECK_LATENCY = 1;

endpackage

// File: rtl/reg_file_test_checker_if.sv
// Register read bus between the checker and the expected/actual sources.
// Data returns one cycle after a reg_read strobe.
interface reg_file_test_checker_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_INDEX_BITS = 5
);

  logic [REG_INDEX_BITS-1:0] reg_index;
  logic                      reg_read;
  logic [DATA_WIDTH-1:0]     exp_data;
  logic [DATA_WIDTH-1:0]     act_data;

  modport master (
    output reg_index,
    output reg_read,
    input  exp_data,
    input  act_data
  );

  modport slave (
    input  reg_index,
    input  reg_read,
    output exp_data,
    output act_data
  );

endinterface

// File: rtl/rf_scan_compare.sv
// Index counter, read/compare pipeline and first-mismatch capture.
// launch starts a scan of every register; clear wipes the results.
module rf_scan_compare
  import rf_check_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_INDEX_BITS = 5,
  parameter int STOP_ON_FAIL   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      launch,
  output logic [REG_INDEX_BITS-1:0] reg_index,
  output logic                      reg_read,
  input  logic [DATA_WIDTH-1:0]     exp_data,
  input  logic [DATA_WIDTH-1:0]     act_data,
  output logic                      scan_done,
  output logic [REG_INDEX_BITS:0]   fail_count,
  output logic [REG_INDEX_BITS-1:0] first_fail_idx,
  output logic [DATA_WIDTH-1:0]     first_fail_exp,
  output logic [DATA_WIDTH-1:0]     first_fail_act
);

  localparam logic [REG_INDEX_BITS-1:0] LAST =
    REG_INDEX_BITS'(NUM_REGS - 1);

  logic                      rd_en;
  logic [CHECK_LATENCY-1:0]  vld_q;
  logic                      cmp_vld;
  logic [REG_INDEX_BITS-1:0] cmp_idx;
  logic                      mismatch;
  logic                      stop_hit;

  assign reg_read  = rd_en;
  assign cmp_vld   = vld_q[CHECK_LATENCY-1];
  assign mismatch  = cmp_vld && (exp_data != act_data);
  assign stop_hit  = (STOP_ON_FAIL != 0) && mismatch;
  assign scan_done = cmp_vld && ((cmp_idx == LAST) || stop_hit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_en     <= 1'b0;
      reg_index <= '0;
      vld_q     <= '0;
      cmp_idx   <= '0;
    end else begin
      if (launch) begin
        rd_en     <= 1'b1;
        reg_index <= '0;
      end else if (rd_en) begin
        if (stop_hit || reg_index == LAST)
          rd_en <= 1'b0;
        else
          reg_index <= reg_index + 1'b1;
      end
      // a stop discards the read already in flight
      if (stop_hit)
        vld_q <= '0;
      else
        vld_q <= CHECK_LATENCY'({vld_q, rd_en});
      if (rd_en)
        cmp_idx <= reg_index;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
    end else if (clear) begin
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
    end else if (mismatch) begin
      fail_count <= fail_count + 1'b1;
      if (fail_count == '0) begin
        first_fail_idx <= cmp_idx;
        first_fail_exp <= exp_data;
        first_fail_act <= act_data;
      end
    end
  end

endmodule

// File: rtl/reg_file_test_checker.sv
// Waits for halt or timeout, then scans the register file against
// an expected table and reports pass/fail with first-mismatch detail.
module reg_file_test_checker
  import rf_check_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_INDEX_BITS = 5,
  parameter int CYCLE_BITS     = 16,
  parameter int STOP_ON_FAIL   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CYCLE_BITS-1:0]     timeout_cycles,
  input  logic                      halt,
  reg_file_test_checker_if.master   rf,
  output logic                      busy,
  output logic                      done,
  output logic                      passed,
  output logic                      timed_out,
  output logic [REG_INDEX_BITS:0]   fail_count,
  output logic [REG_INDEX_BITS-1:0] first_fail_idx,
  output logic [DATA_WIDTH-1:0]     first_fail_exp,
  output logic [DATA_WIDTH-1:0]     first_fail_act,
  output logic [CYCLE_BITS-1:0]     cycles_elapsed
);

  logic [1:0]            state;
  logic [CYCLE_BITS-1:0] timeout_q;
  logic [CYCLE_BITS-1:0] ce_nxt;
  logic                  tmo_hit;
  logic                  go;
  logic                  launch;
  logic                  scan_done;

  assign ce_nxt  = cycles_elapsed + 1'b1;
  assign tmo_hit = (timeout_q != '0) && (ce_nxt == timeout_q);
  assign go      = start && (state == S_IDLE || state == S_DONE);
  assign launch  = (state == S_RUN) && (halt || tmo_hit);

  assign busy   = (state == S_RUN) || (state == S_SCAN);
  assign done   = (state == S_DONE);
  assign passed = done && (fail_count == '0) && !timed_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      timeout_q      <= '0;
      cycles_elapsed <= '0;
      timed_out      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            timeout_q      <= timeout_cycles;
            cycles_elapsed <= '0;
            timed_out      <= 1'b0;
            state          <= S_RUN;
          end
        end
        S_RUN: begin
          if (cycles_elapsed != '1)
            cycles_elapsed <= ce_nxt;
          // halt takes priority over a coincident timeout
          if (halt) begin
            state <= S_SCAN;
          end else if (tmo_hit) begin
            timed_out <= 1'b1;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_done)
            state <= S_DONE;
        end
      endcase
    end
  end

  rf_scan_compare #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_REGS       (NUM_REGS),
    .REG_INDEX_BITS (REG_INDEX_BITS),
    .STOP_ON_FAIL   (STOP_ON_FAIL)
  ) u_scan (
    .clock          (clock),
    .reset          (reset),
    .clear          (go),
    .launch         (launch),
    .reg_index      (rf.reg_index),
    .reg_read       (rf.reg_read),
    .exp_data       (rf.exp_data),
    .act_data       (rf.act_data),
    .scan_done      (scan_done),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .first_fail_exp (first_fail_exp),
    .first_fail_act (first_fail_act)
  );

endmodule
